// File: rtl/rs_pkg.sv
// Shared RS(68,64) definitions over GF(2^8): code geometry, field constants,
// the field multiplier and the decoder state encoding.
package rs_pkg;

  localparam int N    = 68;
  localparam int K    = 64;
  localparam int NPAR = 4;

  // Low byte of the field polynomial x^8+x^4+x^3+x^2+1 (0x11D); the x^8 term
  // is the bit shifted out during reduction.
  localparam logic [7:0] GF_POLY = 8'h1D;
  localparam logic [7:0] ALPHA   = 8'h02;

  typedef logic [7:0]            sym_t;
  typedef logic [0:N-1][7:0]     cw_t;    // index 0 is the first symbol (x^67)
  typedef logic [0:K-1][7:0]     msg_t;
  typedef logic [0:NPAR-1][7:0]  synd_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYND,
    S_CHECK,
    S_SEARCH,
    S_CORRECT,
    S_DONE
  } dec_state_t;

  // Carry-less multiply reduced modulo the field polynomial.
  function automatic sym_t gf_mul(input sym_t a, input sym_t b);
    sym_t acc;
    sym_t sh;
    acc = '0;
    sh  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc ^= sh;
      sh = {sh[6:0], 1'b0} ^ (sh[7] ? GF_POLY : 8'h00);
    end
    return acc;
  endfunction

  // alpha^(k*d), used to build constant multipliers at elaboration time.
  function automatic sym_t gf_alpha_pow(input int k, input int d);
    sym_t base;
    sym_t r;
    base = 8'h01;
    r    = 8'h01;
    for (int j = 0; j < k; j++) base = gf_mul(base, ALPHA);
    for (int j = 0; j < d; j++) r = gf_mul(r, base);
    return r;
  endfunction

endpackage

// File: rtl/rs_decoder_if.sv
// Codeword-in / message-out handshake bundle for the RS decoder.
interface rs_decoder_if;
  import rs_pkg::*;

  cw_t         cw_in;
  logic        cw_valid;
  logic        cw_ready;
  msg_t        msg_out;
  logic        out_valid;
  logic        out_ready;
  logic        err_none;
  logic        err_corrected;
  logic        err_uncorr;
  logic [6:0]  err_idx;

  modport master (
    output cw_in, cw_valid, out_ready,
    input  cw_ready, msg_out, out_valid, err_none, err_corrected, err_uncorr, err_idx
  );

  modport slave (
    input  cw_in, cw_valid, out_ready,
    output cw_ready, msg_out, out_valid, err_none, err_corrected, err_uncorr, err_idx
  );
endinterface

// File: rtl/rs_syndrome.sv
// Combinational syndrome generator: S_k = sum cw[i] * alpha^(k*(67-i)).
module rs_syndrome
  import rs_pkg::*;
(
  input  cw_t   i_cw,
  output synd_t o_synd
);

  for (genvar k = 0; k < NPAR; k++) begin : g_synd
    sym_t w_term [N];
    sym_t w_sum;

    for (genvar i = 0; i < N; i++) begin : g_term
      localparam sym_t C_POW = gf_alpha_pow(k, N - 1 - i);
      assign w_term[i] = gf_mul(i_cw[i], C_POW);
    end

    // XOR-reduce the weighted symbols into one syndrome.
    always_comb begin
      // NOTE: assign a default before the loop so no path leaves w_sum unassigned (no latch).
      w_sum = '0;
      for (int i = 0; i < N; i++) w_sum ^= w_term[i];
    end

    assign o_synd[k] = w_sum;
  end

endmodule

// File: rtl/rs_decoder.sv
// RS(68,64) single-symbol-correcting decoder: syndrome, consistency check,
// sequential error-locator search (one degree per cycle), then correction.
module rs_decoder
  import rs_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  rs_decoder_if.slave  bus
);

  dec_state_t  r_state;
  cw_t         r_cw;
  synd_t       r_synd;
  logic [6:0]  r_d;
  sym_t        r_x;
  logic        r_cw_ready;
  logic        r_out_valid;
  logic        r_err_none;
  logic        r_err_corr;
  logic        r_err_uncorr;
  logic [6:0]  r_err_idx;

  synd_t       w_synd;
  logic        w_synd_zero;
  logic        w_synd_bad;
  logic        w_hit;
  logic [6:0]  w_pos;

  rs_syndrome u_syndrome (
    .i_cw   (r_cw),
    .o_synd (w_synd)
  );

  // A single error of value e at degree d gives S_k = e*alpha^(d*k), so the
  // syndromes must form a geometric sequence with nonzero S0 and S1.
  assign w_synd_zero = (r_synd == '0);
  assign w_synd_bad  = (r_synd[0] == 8'h00) || (r_synd[1] == 8'h00) ||
                       (gf_mul(r_synd[1], r_synd[1]) != gf_mul(r_synd[0], r_synd[2])) ||
                       (gf_mul(r_synd[2], r_synd[2]) != gf_mul(r_synd[1], r_synd[3]));
  assign w_hit       = (gf_mul(r_x, r_synd[0]) == r_synd[1]);
  assign w_pos       = 7'(N - 1) - r_d;

  // Decoder FSM with all datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      // NOTE: the codeword store is reset because msg_out reads it directly and must be 0 in reset.
      r_cw         <= '0;
      r_synd       <= '0;
      r_d          <= '0;
      r_x          <= '0;
      r_cw_ready   <= 1'b0;
      r_out_valid  <= 1'b0;
      r_err_none   <= 1'b0;
      r_err_corr   <= 1'b0;
      r_err_uncorr <= 1'b0;
      r_err_idx    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      case (r_state)
        S_IDLE: begin
          if (bus.cw_valid && r_cw_ready) begin
            r_cw         <= bus.cw_in;
            r_cw_ready   <= 1'b0;
            r_err_none   <= 1'b0;
            r_err_corr   <= 1'b0;
            r_err_uncorr <= 1'b0;
            r_err_idx    <= '0;
            r_state      <= S_SYND;
          end else begin
            r_cw_ready <= 1'b1;
          end
        end
        S_SYND: begin
          r_synd  <= w_synd;
          r_state <= S_CHECK;
        end
        S_CHECK: begin
          if (w_synd_zero) begin
            r_err_none  <= 1'b1;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end else if (w_synd_bad) begin
            r_err_uncorr <= 1'b1;
            r_out_valid  <= 1'b1;
            r_state      <= S_DONE;
          end else begin
            r_d     <= '0;
            r_x     <= 8'h01;
            r_state <= S_SEARCH;
          end
        end
        S_SEARCH: begin
          if (w_hit) begin
            r_state <= S_CORRECT;
          end else if (r_d == 7'(N - 1)) begin
            r_err_uncorr <= 1'b1;
            r_out_valid  <= 1'b1;
            r_state      <= S_DONE;
          end else begin
            r_d <= r_d + 7'd1;
            r_x <= gf_mul(r_x, ALPHA);
          end
        end
        S_CORRECT: begin
          // Parity positions are patched too; they just never reach msg_out.
          r_cw[w_pos] <= r_cw[w_pos] ^ r_synd[0];
          r_err_idx   <= w_pos;
          r_err_corr  <= 1'b1;
          r_out_valid <= 1'b1;
          r_state     <= S_DONE;
        end
        S_DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_cw_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.cw_ready      = r_cw_ready;
  assign bus.msg_out       = r_cw[0:K-1];
  assign bus.out_valid     = r_out_valid;
  assign bus.err_none      = r_err_none;
  assign bus.err_corrected = r_err_corr;
  assign bus.err_uncorr    = r_err_uncorr;
  assign bus.err_idx       = r_err_idx;

endmodule

// File: tb/tb_rs_decoder.sv
// Directed bench for rs_decoder: table of error patterns plus hand-written
// stall and mid-search reset sequences.
module tb_rs_decoder;
  import rs_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rs_decoder_if bus ();

  rs_decoder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    string      name;
    int         p1;
    logic [7:0] v1;
    int         p2;
    logic [7:0] v2;
    int         p3;
    logic [7:0] v3;
    logic [2:0] st;    // {none, corrected, uncorr}
    logic [6:0] idx;
    int         lat;   // 0: not checked
  } vec_t;

  vec_t vecs [9];
  msg_t msg0, msg1;
  cw_t  enc0, enc1;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Bench-side field multiply, MSB-first Horner form.
  function automatic logic [7:0] tb_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      p = {p[6:0], 1'b0} ^ (p[7] ? 8'h1D : 8'h00);
      if (b[i]) p ^= a;
    end
    return p;
  endfunction

  // Systematic encoder: parity = remainder of m(x)*x^4 divided by g(x).
  function automatic cw_t tb_encode(input msg_t m);
    logic [7:0] g [5];
    logic [7:0] a;
    cw_t        r;
    cw_t        c;
    g = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h00};
    a = 8'h01;
    for (int k = 0; k < 4; k++) begin
      for (int j = 4; j >= 1; j--) g[j] = g[j-1] ^ tb_mul(g[j], a);
      g[0] = tb_mul(g[0], a);
      a = tb_mul(a, 8'h02);
    end
    r = '0;
    for (int i = 0; i < 64; i++) r[i] = m[i];
    for (int i = 0; i < 64; i++) begin
      logic [7:0] f;
      f = r[i];
      for (int j = 1; j <= 4; j++) r[i+j] ^= tb_mul(f, g[4-j]);
    end
    c = '0;
    for (int i = 0; i < 64; i++) c[i] = m[i];
    for (int i = 64; i < 68; i++) c[i] = r[i];
    return c;
  endfunction

  function automatic logic [2:0] status();
    return {bus.err_none, bus.err_corrected, bus.err_uncorr};
  endfunction

  // Present one codeword and count edges after the accepting edge until out_valid.
  task automatic run_word(input string name, input cw_t cw, output int lat);
    lat = -1;
    @(negedge clk);
    bus.cw_in    = cw;
    bus.cw_valid = 1'b1;
    @(posedge clk);
    #1 bus.cw_valid = 1'b0;
    for (int c = 1; c <= 200; c++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) begin
        lat = c;
        break;
      end
    end
    if (lat < 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s_timeout: got no out_valid, expected it within 200 cycles", name);
    end
  endtask

  task automatic handshake(input string name);
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    check({name, "_ov_drop"}, bus.out_valid, 1'b0);
    check({name, "_ready_back"}, bus.cw_ready, 1'b1);
  endtask

  initial begin
    cw_t  cw;
    msg_t exp_msg;
    int   lat;
    int   seen;

    bus.cw_in     = '0;
    bus.cw_valid  = 1'b0;
    bus.out_ready = 1'b0;

    for (int i = 0; i < 64; i++) begin
      msg0[i] = 8'(i);
      msg1[i] = 8'(255 - i);
    end
    enc0 = tb_encode(msg0);
    enc1 = tb_encode(msg1);

    vecs[0] = '{"clean",     -1, 8'h00, -1, 8'h00, -1, 8'h00, 3'b100, 7'd0,  2};
    vecs[1] = '{"err10",     10, 8'h5A, -1, 8'h00, -1, 8'h00, 3'b010, 7'd10, 61};
    vecs[2] = '{"err67",     67, 8'h01, -1, 8'h00, -1, 8'h00, 3'b010, 7'd67, 4};
    vecs[3] = '{"err0_1",     0, 8'h01,  1, 8'h01, -1, 8'h00, 3'b001, 7'd0,  2};
    vecs[4] = '{"err64",     64, 8'hFF, -1, 8'h00, -1, 8'h00, 3'b010, 7'd64, 7};
    vecs[5] = '{"err63",     63, 8'h80, -1, 8'h00, -1, 8'h00, 3'b010, 7'd63, 8};
    vecs[6] = '{"err0",       0, 8'h33, -1, 8'h00, -1, 8'h00, 3'b010, 7'd0,  71};
    vecs[7] = '{"two_err",    5, 8'h11, 20, 8'h22, -1, 8'h00, 3'b001, 7'd0,  0};
    vecs[8] = '{"three_err",  2, 8'h01, 30, 8'h07, 65, 8'hC3, 3'b001, 7'd0,  0};

    // Reset state while rst_n is held low.
    #12;
    check("rst_cw_ready",  bus.cw_ready, 1'b0);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_msg",       bus.msg_out, '0);
    check("rst_status",    status(), 3'b000);
    check("rst_idx",       bus.err_idx, 7'd0);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1 check("rst_release_ready", bus.cw_ready, 1'b1);

    // Table-driven error patterns.
    for (int v = 0; v < 9; v++) begin
      cw = enc0;
      if (vecs[v].p1 >= 0) cw[vecs[v].p1] ^= vecs[v].v1;
      if (vecs[v].p2 >= 0) cw[vecs[v].p2] ^= vecs[v].v2;
      if (vecs[v].p3 >= 0) cw[vecs[v].p3] ^= vecs[v].v3;
      exp_msg = (vecs[v].st == 3'b001) ? msg_t'(cw[0:K-1]) : msg0;
      run_word(vecs[v].name, cw, lat);
      if (lat >= 0) begin
        if (vecs[v].lat > 0) check({vecs[v].name, "_latency"}, lat, vecs[v].lat);
        check({vecs[v].name, "_status"}, status(), vecs[v].st);
        check({vecs[v].name, "_idx"}, bus.err_idx, vecs[v].idx);
        check({vecs[v].name, "_msg"}, bus.msg_out, exp_msg);
      end
      handshake(vecs[v].name);
    end

    // Stall in DONE with a second word already offered.
    run_word("stall", enc0, lat);
    @(negedge clk);
    bus.cw_in    = enc1;
    bus.cw_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      check("stall_out_valid", bus.out_valid, 1'b1);
      check("stall_cw_ready",  bus.cw_ready, 1'b0);
      check("stall_msg",       bus.msg_out, msg0);
      check("stall_status",    status(), 3'b100);
    end
    @(negedge clk) bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    check("stall_ready_after_hs", bus.cw_ready, 1'b1);
    @(posedge clk);
    #1 bus.cw_valid = 1'b0;
    check("stall_second_taken", bus.cw_ready, 1'b0);
    lat = -1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) begin
        lat = c;
        break;
      end
    end
    check("second_latency", lat, 2);
    check("second_status",  status(), 3'b100);
    check("second_msg",     bus.msg_out, msg1);
    handshake("second");

    // Reset pulse while the locator search is running.
    cw = enc0;
    cw[10] ^= 8'h5A;
    @(negedge clk);
    bus.cw_in    = cw;
    bus.cw_valid = 1'b1;
    @(posedge clk);
    #1 bus.cw_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    #1;
    check("midrst_out_valid", bus.out_valid, 1'b0);
    check("midrst_msg",       bus.msg_out, '0);
    check("midrst_cw_ready",  bus.cw_ready, 1'b0);
    check("midrst_status",    status(), 3'b000);
    @(negedge clk) rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 80; c++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) seen++;
    end
    check("midrst_no_result", seen, 0);
    check("midrst_ready",     bus.cw_ready, 1'b1);
    run_word("post_rst", enc0, lat);
    if (lat >= 0) begin
      check("post_rst_latency", lat, 2);
      check("post_rst_status",  status(), 3'b100);
      check("post_rst_msg",     bus.msg_out, msg0);
    end
    handshake("post_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rs_decoder.md
RS_DECODER -- requirements
Module: rs_decoder

Interface
REQ-001 Parameters: none; code fixed at RS(68,64) over GF(2^8), field polynomial x^8+x^4+x^3+x^2+1 (0x11D), alpha=0x02, generator roots alpha^0..alpha^3.
REQ-002 clk  input  1  single clock, all state on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 cw_in  input  8 x [68]  received codeword: [0..63] message symbols, [64..67] parity symbols, as produced by rs_encoder (msg_in, then parity_out[0..3]).
REQ-005 cw_valid  input  1  cw_in valid.
REQ-006 cw_ready  output  1  decoder can accept; transfer on clk edge with cw_valid && cw_ready.
REQ-007 msg_out  output  8 x [64]  corrected (or raw, if uncorrectable) message.
REQ-008 out_valid  output  1  result valid.
REQ-009 out_ready  input  1  downstream accepts; transfer on clk edge with out_valid && out_ready.
REQ-010 err_none / err_corrected / err_uncorr  output  1 each  one-hot status, valid with out_valid.
REQ-011 err_idx  output  7  cw_in index (0..67) of the corrected symbol; 0 unless err_corrected.

Function
REQ-012 Codeword polynomial: cw_in[i] is the coefficient of x^(67-i); degree d = 67-i.
REQ-013 Syndromes: S_k = sum over i of cw_in[i]*alpha^(k*(67-i)), k=0..3; all-zero means valid codeword.
REQ-014 States: IDLE, SYND, CHECK, SEARCH, CORRECT, DONE; cw_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-015 IDLE: on accept, register cw_in -> SYND.
REQ-016 SYND: register S0..S3 from registered codeword -> CHECK.
REQ-017 CHECK: all S zero -> DONE, err_none; else if S0==0, S1==0, S1^2!=S0*S2 or S2^2!=S1*S3 -> DONE, err_uncorr; else -> SEARCH with d=0, X=1.
REQ-018 SEARCH: one degree per cycle; X*S0==S1 -> CORRECT with pos d; else if d==67 -> DONE, err_uncorr; else d+1, X*=alpha.
REQ-019 CORRECT: XOR S0 into stored symbol at index 67-d; err_idx = 67-d; index >= 64 leaves msg_out unchanged but still reports err_corrected -> DONE.
REQ-020 Latency from accepting edge E0: DONE entered at E0+2 for err_none or CHECK-time err_uncorr, E0+4+d for a correction at degree d, E0+70 for search exhaustion.
REQ-021 DONE: msg_out, status and err_idx held stable while out_valid && !out_ready; on handshake -> IDLE; cw_ready reasserts the cycle after.
REQ-022 One codeword in flight; no input accepted outside IDLE (no overlap).
REQ-023 Uncorrectable: msg_out = received message symbols unmodified.
REQ-024 Guarantees: any single symbol error corrected; any 2 or 3 symbol errors reported err_uncorr, never miscorrected.
REQ-025 GF multiply is carry-less product reduced by 0x11D; addition is XOR.

Reset
REQ-026 rst_n low: state IDLE immediately; cw_ready=0 while in reset, 1 after release; out_valid, msg_out, all status flags and err_idx = 0; internal codeword, syndrome, d and X registers = 0.
REQ-027 Reset mid-operation aborts the word with no output; next word decodes normally.

Structure
REQ-028 Shared package rs_pkg: N=68, K=64, NPAR=4, GF_POLY=8'h1D, ALPHA=8'h02, gf_mul function, decoder state enum.
REQ-029 Encoder and decoder both use rs_pkg constants and gf_mul; no local copies.
REQ-030 One sub-module, rs_syndrome: combinational, 68 symbols in, S0..S3 out, constant-power multipliers.
REQ-031 Target 120-400 lines RTL total.

Verification
REQ-032 msg[i]=i encoded by rs_encoder, no error -> err_none, msg_out==msg, out_valid at E0+2.
REQ-033 Same word, cw[10]^=8'h5A -> err_corrected, err_idx=10, msg_out==msg, out_valid at E0+61 (d=57).
REQ-034 cw[67]^=8'h01 -> err_corrected, err_idx=67, msg_out==msg, out_valid at E0+4.
REQ-035 cw[0]^=8'h01 and cw[1]^=8'h01 -> err_uncorr, err_idx=0, msg_out==received msg.
REQ-036 out_ready held low 5 cycles in DONE -> outputs stable, cw_ready=0, second cw_valid ignored until handshake.
REQ-037 rst_n pulsed low during SEARCH -> out_valid=0, msg_out=0, no result; after release cw_ready=1 and the next clean word gives err_none.
